// File: rtl/type_enums.sv
// Shared execute-stage operation encodings: ALU ops and RV32M multiply/divide ops,
// plus small decode helpers for the muldiv sequencer.
package type_enums;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_XOR = 4'd4,
      ALU_SLL = 4'd5,
      ALU_SRL = 4'd6,
      ALU_SRA = 4'd7
   } alu_op_t;

   // Encodings 3'd6 and 3'd7 are undefined and complete in one cycle with all-ones.
   typedef enum logic [2:0] {
      MD_MUL   = 3'd0,
      MD_MULHU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_REM   = 3'd4,
      MD_REMU  = 3'd5
   } md_op_t;

   function automatic logic md_defined(input md_op_t op);
      return op inside {MD_MUL, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU};
   endfunction

   function automatic logic md_is_divrem(input md_op_t op);
      return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
   endfunction

   function automatic logic md_is_rem(input md_op_t op);
      return op inside {MD_REM, MD_REMU};
   endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative RV32M mul/div borrowing the execute ALU while busy; fixed 36-cycle latency
// (1 cycle for divide-by-zero / undefined op); response valid holds until resp_ready.
module muldiv_seq
   import type_enums::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  md_op_t           req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic             kill,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_data,
   output logic             busy,
   output alu_op_t          alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_out,
   input  logic [3:0]       alu_flags
);

   typedef enum logic [2:0] {IDLE, NEGA, NEGB, ITER, FIX, DONE} state_t;

   state_t           state, state_nxt;
   md_op_t           op;
   logic [WIDTH-1:0] a_reg, b_reg, hi, lo;
   logic [5:0]       cnt;
   logic             sign_a, sign_b;

   logic             accept, fast, op_signed, op_mul, fix_neg, carry, div_take;
   logic [WIDTH-1:0] r_shift, result_sel;
   logic             flags_unused;

   assign carry        = alu_flags[1];
   assign flags_unused = ^{alu_flags[3:2], alu_flags[0]};

   assign req_ready  = (state == IDLE);
   assign busy       = (state != IDLE);
   assign resp_valid = (state == DONE);

   assign accept    = (state == IDLE) && req_valid && !kill;
   assign fast      = !md_defined(req_op) || (md_is_divrem(req_op) && (req_b == '0));
   assign op_signed = (op == MD_DIV) || (op == MD_REM);
   assign op_mul    = (op == MD_MUL) || (op == MD_MULHU);

   // Restoring step: the bit shifted out of R makes the partial remainder exceed B.
   assign r_shift  = {hi[WIDTH-2:0], lo[WIDTH-1]};
   assign div_take = hi[WIDTH-1] || !carry;

   always_comb begin
      result_sel = lo;
      case (op)
         MD_MUL:           result_sel = lo;
         MD_MULHU:         result_sel = hi;
         MD_DIV, MD_DIVU:  result_sel = lo;
         MD_REM, MD_REMU:  result_sel = hi;
         default:          result_sel = lo;
      endcase
   end

   assign fix_neg = ((op == MD_DIV) && (sign_a ^ sign_b)) || ((op == MD_REM) && sign_a);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      alu_op    = ALU_ADD;
      alu_a     = '0;
      alu_b     = '0;
      case (state)
         IDLE: if (accept) state_nxt = fast ? DONE : NEGA;
         NEGA: begin
            alu_op    = ALU_SUB;
            alu_b     = a_reg;
            state_nxt = NEGB;
         end
         NEGB: begin
            alu_op    = ALU_SUB;
            alu_b     = b_reg;
            state_nxt = ITER;
         end
         ITER: begin
            if (op_mul) begin
               alu_op = ALU_ADD;
               alu_a  = hi;
               alu_b  = lo[0] ? b_reg : '0;
            end else begin
               alu_op = ALU_SUB;
               alu_a  = r_shift;
               alu_b  = b_reg;
            end
            if (cnt == 6'd31) state_nxt = FIX;
         end
         FIX: begin
            alu_op    = ALU_SUB;
            alu_b     = result_sel;
            state_nxt = DONE;
         end
         DONE:    if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (kill && (state != IDLE)) state_nxt = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op        <= MD_MUL;
         a_reg     <= '0;
         b_reg     <= '0;
         hi        <= '0;
         lo        <= '0;
         cnt       <= '0;
         sign_a    <= 1'b0;
         sign_b    <= 1'b0;
         resp_data <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               op    <= req_op;
               a_reg <= req_a;
               b_reg <= req_b;
               if (!md_defined(req_op))
                  resp_data <= '1;
               else if (md_is_divrem(req_op) && (req_b == '0))
                  resp_data <= md_is_rem(req_op) ? req_a : '1;
            end
            NEGA: begin
               sign_a <= op_signed && a_reg[WIDTH-1];
               if (op_signed && a_reg[WIDTH-1]) a_reg <= alu_out;
            end
            NEGB: begin
               sign_b <= op_signed && b_reg[WIDTH-1];
               if (op_signed && b_reg[WIDTH-1]) b_reg <= alu_out;
               hi  <= '0;
               lo  <= a_reg;
               cnt <= '0;
            end
            ITER: begin
               cnt <= cnt + 6'd1;
               if (op_mul) begin
                  hi <= {carry, alu_out[WIDTH-1:1]};
                  lo <= {alu_out[0], lo[WIDTH-1:1]};
               end else begin
                  hi <= div_take ? alu_out : r_shift;
                  lo <= {lo[WIDTH-2:0], div_take};
               end
            end
            FIX:     resp_data <= fix_neg ? alu_out : result_sel;
            default: ;
         endcase
      end
   end

endmodule
